// File: rtl/dsc_serial_mul3_pkg.sv
// dsc_pkg: shared definitions for the deterministic stochastic-computing
// (DSC) serial multiplier blocks.
//   N_IN          number of multiplied operands / cascaded counters
//   prod_w(w)     width of the product and of the enumeration space
//   stream_vec_t  one unary stream bit per operand
package dsc_pkg;

  localparam int N_IN = 3;

  function automatic int prod_w(input int w);
    return N_IN * w;
  endfunction

  typedef logic [N_IN-1:0] stream_vec_t;

endpackage

// File: rtl/dsc_up_counter.sv
// dsc_up_counter: free-running up counter with carry-out.
//   clk       rising-edge clock
//   rst       synchronous active-high reset, clears out
//   en        increment enable
//   out       counter value
//   overflow  en & (&out): high on the enabled cycle that wraps out to 0
module dsc_up_counter #(
  parameter int WIDTH = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic [WIDTH-1:0] out,
  output logic             overflow
);

  always_ff @(posedge clk) begin
    if (rst)     out <= '0;
    else if (en) out <= out + 1'b1;
  end

  assign overflow = en & (&out);

endmodule

// File: rtl/dsc_serial_mul3.sv
// dsc_serial_mul3: three-operand DSC multiplier by serial exhaustive
// enumeration. Three cascaded WIDTH-bit counters walk every combination of
// counter states exactly once; each operand becomes a unary stream
// (operand > its counter) and the AND of the streams is accumulated into z,
// which ends at exactly a*b*c after 2^(3*WIDTH) enabled cycles.
//   clk  rising-edge clock
//   rst  synchronous active-high reset (priority over en)
//   en   advance enable; low holds all state
//   a,b,c  unsigned operands, held stable from reset release until ov
//   z    accumulated product (3*WIDTH bits, registered)
//   ov   sticky done flag (registered), cleared only by rst
// Optional build macro DSC_ZERO_SKIP_EN: any zero operand finishes in one
// enabled cycle with z = 0 instead of enumerating the full space.
module dsc_serial_mul3
  import dsc_pkg::*;
#(
  parameter int WIDTH = 6
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic [WIDTH-1:0]          a,
  input  logic [WIDTH-1:0]          b,
  input  logic [WIDTH-1:0]          c,
  output logic [prod_w(WIDTH)-1:0]  z,
  output logic                      ov
);

  localparam int PW = prod_w(WIDTH);

  logic [N_IN-1:0][WIDTH-1:0] opnd;
  logic [N_IN-1:0][WIDTH-1:0] ctr;
  stream_vec_t                strm;
  stream_vec_t                cas_en;
  stream_vec_t                cas_ovf;
  logic                       run;
  logic                       p;
  logic                       ov_set;
  logic                       unused_z_ovf;

  // Lane 0 = a (fastest counter), lane N_IN-1 = c (slowest).
  assign opnd = {c, b, a};

`ifdef DSC_ZERO_SKIP_EN
  logic zero_hit;
  assign zero_hit = (a == '0) | (b == '0) | (c == '0);
  // A zero operand forces the product to 0: finish immediately, freeze state.
  assign run    = en & ~ov & ~zero_hit;
  assign ov_set = cas_ovf[N_IN-1] | (en & ~ov & zero_hit);
`else
  assign run    = en & ~ov;
  assign ov_set = cas_ovf[N_IN-1];
`endif

  // Counter cascade: each lane advances on the wrap of the lane below it.
  for (genvar gi = 0; gi < N_IN; gi++) begin : g_lane
    if (gi == 0) begin : g_first
      assign cas_en[gi] = run;
    end else begin : g_next
      assign cas_en[gi] = cas_ovf[gi-1];
    end

    dsc_up_counter #(.WIDTH(WIDTH)) u_ctr (
      .clk      (clk),
      .rst      (rst),
      .en       (cas_en[gi]),
      .out      (ctr[gi]),
      .overflow (cas_ovf[gi])
    );

    assign strm[gi] = opnd[gi] > ctr[gi];
  end

  assign p = &strm;

  // Product accumulator; max (2^W-1)^3 < 2^(3W), so it never wraps.
  dsc_up_counter #(.WIDTH(PW)) u_acc (
    .clk      (clk),
    .rst      (rst),
    .en       (run & p),
    .out      (z),
    .overflow (unused_z_ovf)
  );

  always_ff @(posedge clk) begin
    if (rst)         ov <= 1'b0;
    else if (ov_set) ov <= 1'b1;
  end

endmodule

// File: tb/tb_dsc_serial_mul3.sv
module tb_dsc_serial_mul3;

  // Reduced operand width keeps each full enumeration at 512 cycles.
  localparam int W    = 3;
  localparam int PW   = 3 * W;
  localparam int FULL = 1 << PW;
  localparam int LIMIT = 4 * FULL + 400;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en  = 1'b0;
  logic [W-1:0]  a = '0, b = '0, c = '0;
  logic [PW-1:0] z;
  logic          ov;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int z;
    int lat;
  } exp_t;
  exp_t sb_q[$];

  int en_cnt = 0;
  logic ov_prev = 1'b0;

  dsc_serial_mul3 #(.WIDTH(W)) dut (
    .clk (clk), .rst (rst), .en (en),
    .a (a), .b (b), .c (c),
    .z (z), .ov (ov)
  );

  always #5 clk = ~clk;

  // Enabled-cycle counter for latency: edges with en high while not done.
  always @(posedge clk) begin
    if (rst)            en_cnt <= 0;
    else if (en && !ov) en_cnt <= en_cnt + 1;
  end

  // Reference: product by plain multiplication, latency from the rules.
  function automatic exp_t model(input int ma, input int mb, input int mc);
    exp_t e;
    e.z   = ma * mb * mc;
    e.lat = FULL;
`ifdef DSC_ZERO_SKIP_EN
    if (ma == 0 || mb == 0 || mc == 0) e.lat = 1;
`endif
    return e;
  endfunction

  // Monitor: on every rising ov, pop and compare result and latency.
  always @(negedge clk) begin
    if (ov && !ov_prev) begin
      if (sb_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_ov: ov rose with no outstanding operation, z=%0d", z);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        checks++;
        if (z !== PW'(e.z)) begin
          errors++;
          $display("FAIL product: z=%0d expected %0d", z, e.z);
        end
        checks++;
        if (en_cnt != e.lat) begin
          errors++;
          $display("FAIL latency: enabled_cycles=%0d expected %0d", en_cnt, e.lat);
        end
      end
    end
    ov_prev <= ov;
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; en = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    checks++;
    if (z !== '0 || ov !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: z=%0d ov=%0b expected z=0 ov=0", z, ov);
    end
  endtask

  // One full operation; gap>0 alternates gap enabled / gap idle cycles.
  task automatic run_op(input int ta, input int tb_, input int tc,
                        input int gap, input bit hold_check);
    exp_t e;
    bit   done;
    do_reset();
    a = W'(ta); b = W'(tb_); c = W'(tc);
    e = model(ta, tb_, tc);
    sb_q.push_back(e);
    done = 1'b0;
    for (int n = 0; n < LIMIT; n++) begin
      en = (gap > 0) ? (((n / gap) % 2) == 0) : 1'b1;
      @(negedge clk);
      if (n == 0 && e.z == 1 && e.lat == FULL) begin
        checks++;
        if (z !== PW'(1)) begin
          errors++;
          $display("FAIL first_cycle: z=%0d expected 1", z);
        end
      end
      if (ov) begin done = 1'b1; break; end
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL timeout: ov=%0b after %0d cycles, a=%0d b=%0d c=%0d", ov, LIMIT, ta, tb_, tc);
      void'(sb_q.pop_back());
    end else if (hold_check) begin
      en = 1'b1;
      for (int k = 0; k < 10; k++) begin
        @(negedge clk);
        checks++;
        if (z !== PW'(e.z) || ov !== 1'b1) begin
          errors++;
          $display("FAIL hold: z=%0d ov=%0b expected z=%0d ov=1", z, ov, e.z);
        end
      end
    end
    en = 1'b0;
  endtask

  initial begin
    // Maximum operands, then stability after done.
    run_op(7, 7, 7, 0, 1'b1);
    // Unit operands: single count on the very first enabled cycle.
    run_op(1, 1, 1, 0, 1'b1);
    // Zero operand.
    run_op(5, 0, 3, 0, 1'b1);
    // Enable gaps: latency in enabled cycles is unchanged.
    run_op(3, 6, 5, 100, 1'b0);

    // Reset mid-operation, then rerun.
    do_reset();
    a = 3'd7; b = 3'd7; c = 3'd7;
    en = 1'b1;
    repeat (100) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; en = 1'b0;
    checks++;
    if (z !== '0 || ov !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: z=%0d ov=%0b expected z=0 ov=0", z, ov);
    end
    run_op(7, 6, 2, 0, 1'b0);

    // Randomized operands.
    for (int r = 0; r < 40; r++) begin
      run_op(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
             int'($urandom_range(0, 7)), 0, 1'b0);
    end

    repeat (3) @(negedge clk);
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left expected 0", sb_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
